as_gpio_arb: RTL and testbench

AS_GPIO_ARB -- requirements
Module: as_gpio_arb

---
 rtl/as_pack.sv | 24 ++
 rtl/as_rr_arb.sv | 54 +++++
 rtl/as_gpio_arb.sv | 160 ++++++++++++++++
 tb/tb_as_gpio_arb.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/as_pack.sv
// -----------------------------------------------------------------------------
// as_pack
// Shared constants and types for the GPIO arbiter slice.
//   nr_gpios         : width of the GPIO data bus driven to the pads
//   gpio_addr_width  : width of the GPIO address bus
//   gpio_arb_state_t : arbiter FSM state encoding
//   max_int          : elaboration-time helper for counter sizing
// -----------------------------------------------------------------------------
package as_pack;

  localparam int nr_gpios        = 8;
  localparam int gpio_addr_width = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } gpio_arb_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/as_rr_arb.sv
// -----------------------------------------------------------------------------
// as_rr_arb
// Round-robin picker with its own last-grant pointer.
//   clk_i          : clock
//   rstn_i         : asynchronous active-low reset (pointer -> NR_REQ-1)
//   req_i          : request vector
//   update_i       : commit the current grant as the new last-grant
//   grant_onehot_o : combinational one-hot pick, searching from last+1
// -----------------------------------------------------------------------------
module as_rr_arb #(
  parameter int NR_REQ = 2
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [NR_REQ-1:0] req_i,
  input  logic              update_i,
  output logic [NR_REQ-1:0] grant_onehot_o
);

  localparam int IW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(NR_REQ - 1);

  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    grant_onehot_o = '0;
    found          = 1'b0;
    idx            = '0;
    for (int i = 1; i <= NR_REQ; i++) begin
      idx = IW'((int'(last_q) + i) % NR_REQ);
      if (!found && req_i[idx]) begin
        grant_onehot_o[idx] = 1'b1;
        found               = 1'b1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (update_i) begin
      for (int i = 0; i < NR_REQ; i++) begin
        if (grant_onehot_o[i]) last_d = IW'(i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) last_q <= LAST_RST;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/as_gpio_arb.sv
// -----------------------------------------------------------------------------
// as_gpio_arb
// Shares one GPIO output port between NR_REQ requesters. One transaction is
// accepted in IDLE, driven with cs for CS_LEN cycles, then followed by GAP_LEN
// idle cycles.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   req_valid_i   : per-requester write request
//   req_addr_i    : per-requester address, slice k = requester k
//   req_data_i    : per-requester data, slice k = requester k
//   req_ready_o   : one-hot accept (combinational, IDLE only)
//   grant_o       : one-hot owner during DRIVE
//   gpio_o        : latched data
//   gpio_oe_o     : pad output enable
//   gpio_addr_o   : latched address
//   cs_o          : chip-select strobe
//   busy_o        : high outside IDLE
//
// state    | meaning
// ST_IDLE  | waiting for a valid requester, ready offered to the RR pick
// ST_DRIVE | cs/oe high, latched data on the pads
// ST_GAP   | enforced idle between transactions
// -----------------------------------------------------------------------------
module as_gpio_arb
  import as_pack::*;
#(
  parameter int NR_REQ  = 2,
  parameter int CS_LEN  = 2,
  parameter int GAP_LEN = 1
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic [NR_REQ-1:0]                 req_valid_i,
  input  logic [NR_REQ*gpio_addr_width-1:0] req_addr_i,
  input  logic [NR_REQ*nr_gpios-1:0]        req_data_i,
  output logic [NR_REQ-1:0]                 req_ready_o,
  output logic [NR_REQ-1:0]                 grant_o,
  output logic [nr_gpios-1:0]               gpio_o,
  output logic                              gpio_oe_o,
  output logic [gpio_addr_width-1:0]        gpio_addr_o,
  output logic                              cs_o,
  output logic                              busy_o
);

  localparam int CNT_W = $clog2(max_int(CS_LEN, GAP_LEN) + 1);
  localparam int IW    = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam logic [CNT_W-1:0] CS_LOAD  = CNT_W'(CS_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;

  gpio_arb_state_t state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [NR_REQ-1:0]          grant_q, grant_d;
  logic [nr_gpios-1:0]        gpio_q;
  logic [gpio_addr_width-1:0] addr_q;
  logic                       cs_q;
  logic                       oe_q;

  logic [NR_REQ-1:0] rr_gnt;
  logic              accept;
  logic              update;
  logic [IW-1:0]     sel;

  logic [nr_gpios-1:0]        data_arr [NR_REQ];
  logic [gpio_addr_width-1:0] addr_arr [NR_REQ];

  for (genvar g = 0; g < NR_REQ; g++) begin : g_slice
    assign data_arr[g] = req_data_i[g*nr_gpios +: nr_gpios];
    assign addr_arr[g] = req_addr_i[g*gpio_addr_width +: gpio_addr_width];
  end

  as_rr_arb #(.NR_REQ(NR_REQ)) u_rr (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .req_i          (req_valid_i),
    .update_i       (update),
    .grant_onehot_o (rr_gnt)
  );

  // Ready is masked by reset so no accept is ever offered while held in reset.
  assign req_ready_o = (state_q == ST_IDLE && rstn_i) ? rr_gnt : '0;
  assign accept      = |(req_valid_i & req_ready_o);
  assign busy_o      = (state_q != ST_IDLE);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (rr_gnt[i]) sel = IW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    update  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_DRIVE;
          cnt_d   = CS_LOAD;
          update  = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          if (GAP_LEN > 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    grant_d = '0;
    if (accept)                   grant_d = rr_gnt;
    else if (state_d == ST_DRIVE) grant_d = grant_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      gpio_q  <= '0;
      addr_q  <= '0;
      cs_q    <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      cs_q    <= (state_d == ST_DRIVE);
      oe_q    <= (state_d == ST_DRIVE);
      if (accept) begin
        gpio_q <= data_arr[sel];
        addr_q <= addr_arr[sel];
      end
    end
  end

  assign grant_o     = grant_q;
  assign gpio_o      = gpio_q;
  assign gpio_addr_o = addr_q;
  assign cs_o        = cs_q;
  assign gpio_oe_o   = oe_q;

endmodule

// File: tb/tb_as_gpio_arb.sv
// -----------------------------------------------------------------------------
// tb_as_gpio_arb
// Directed, table-driven bench for as_gpio_arb (NR_REQ=2, CS_LEN=2, GAP_LEN=1).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_as_gpio_arb;
  import as_pack::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  valid;
  logic [7:0]  d0, d1;
  logic [3:0]  a0, a1;
  logic [1:0]  ready, grant;
  logic [7:0]  gpio;
  logic [3:0]  gaddr;
  logic        oe, cs, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  as_gpio_arb #(.NR_REQ(2), .CS_LEN(2), .GAP_LEN(1)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .req_valid_i (valid),
    .req_addr_i  ({a1, a0}),
    .req_data_i  ({d1, d0}),
    .req_ready_o (ready),
    .grant_o     (grant),
    .gpio_o      (gpio),
    .gpio_oe_o   (oe),
    .gpio_addr_o (gaddr),
    .cs_o        (cs),
    .busy_o      (busy)
  );

  typedef struct packed {
    logic       rst;
    logic [1:0] v;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [3:0] a0;
    logic [3:0] a1;
    logic [1:0] rdy;
    logic       cs;
    logic [1:0] gnt;
    logic [7:0] gpio;
    logic [3:0] addr;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row=%0d actual=0x%0h required=0x%0h @%0t", name, row, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn  = 1'b0;
    valid = 2'b00;
    @(negedge clk);
    rstn  = 1'b1;
  endtask

  function automatic vec_t mk(input logic rst, input logic [1:0] v,
                              input logic [7:0] xd0, input logic [3:0] xa0,
                              input logic [7:0] xd1, input logic [3:0] xa1,
                              input logic [1:0] rdy, input logic xcs,
                              input logic [1:0] gnt, input logic [7:0] g,
                              input logic [3:0] ad, input logic b);
    vec_t r;
    r = '{rst, v, xd0, xd1, xa0, xa1, rdy, xcs, gnt, g, ad, b};
    return r;
  endfunction

  initial begin
    rstn  = 1'b0;
    valid = 2'b11;
    d0 = 8'h01; d1 = 8'h02; a0 = 4'd1; a1 = 4'd2;

    // Reset held with both requesters active: everything stays zero.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("rst_ready", i, 32'(ready), 32'h0);
      chk("rst_outs", i, {cs, oe, busy, grant, gpio, gaddr}, 32'h0);
    end
    @(negedge clk);
    rstn  = 1'b1;
    valid = 2'b00;

    // Single request, data change after accept, req1 withdrawal while busy,
    // then pointer check (req1 must win next since req0 was last).
    //          rst   v      d0     a0    d1     a1    rdy    cs    gnt    gpio   addr  busy
    tbl.push_back(mk(1'b0, 2'b01, 8'h04, 4'd4, 8'h55, 4'd5, 2'b01, 1'b0, 2'b00, 8'h00, 4'd0, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 8'h07, 4'd9, 8'h55, 4'd5, 2'b00, 1'b1, 2'b01, 8'h04, 4'd4, 1'b1));
    tbl.push_back(mk(1'b0, 2'b10, 8'h07, 4'd9, 8'h55, 4'd5, 2'b00, 1'b1, 2'b01, 8'h04, 4'd4, 1'b1));
    tbl.push_back(mk(1'b0, 2'b00, 8'h07, 4'd9, 8'h55, 4'd5, 2'b00, 1'b0, 2'b00, 8'h04, 4'd4, 1'b1));
    tbl.push_back(mk(1'b0, 2'b00, 8'h07, 4'd9, 8'h55, 4'd5, 2'b00, 1'b0, 2'b00, 8'h04, 4'd4, 1'b0));
    tbl.push_back(mk(1'b0, 2'b11, 8'h07, 4'd9, 8'h55, 4'd5, 2'b10, 1'b0, 2'b00, 8'h04, 4'd4, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 8'h07, 4'd9, 8'h55, 4'd5, 2'b00, 1'b1, 2'b10, 8'h55, 4'd5, 1'b1));
    tbl.push_back(mk(1'b0, 2'b00, 8'h07, 4'd9, 8'h55, 4'd5, 2'b00, 1'b1, 2'b10, 8'h55, 4'd5, 1'b1));
    tbl.push_back(mk(1'b0, 2'b00, 8'h07, 4'd9, 8'h55, 4'd5, 2'b00, 1'b0, 2'b00, 8'h55, 4'd5, 1'b1));
    tbl.push_back(mk(1'b0, 2'b00, 8'h07, 4'd9, 8'h55, 4'd5, 2'b00, 1'b0, 2'b00, 8'h55, 4'd5, 1'b0));
    // Contention after reset: 0x1,0x2,0x1,0x2, one transaction every 4 cycles.
    for (int t = 0; t < 4; t++) begin
      logic [1:0] own;
      logic [7:0] dat;
      logic [3:0] adr;
      logic [7:0] prev;
      logic [3:0] padr;
      own  = (t % 2 == 0) ? 2'b01 : 2'b10;
      dat  = (t % 2 == 0) ? 8'h01 : 8'h02;
      adr  = (t % 2 == 0) ? 4'd1  : 4'd2;
      prev = (t == 0) ? 8'h00 : ((t % 2 == 0) ? 8'h02 : 8'h01);
      padr = (t == 0) ? 4'd0  : ((t % 2 == 0) ? 4'd2  : 4'd1);
      tbl.push_back(mk(t == 0, 2'b11, 8'h01, 4'd1, 8'h02, 4'd2, own,   1'b0, 2'b00, prev, padr, 1'b0));
      tbl.push_back(mk(1'b0,   2'b11, 8'h01, 4'd1, 8'h02, 4'd2, 2'b00, 1'b1, own,   dat,  adr,  1'b1));
      tbl.push_back(mk(1'b0,   2'b11, 8'h01, 4'd1, 8'h02, 4'd2, 2'b00, 1'b1, own,   dat,  adr,  1'b1));
      tbl.push_back(mk(1'b0,   2'b11, 8'h01, 4'd1, 8'h02, 4'd2, 2'b00, 1'b0, 2'b00, dat,  adr,  1'b1));
    end

    for (int r = 0; r < tbl.size(); r++) begin
      if (tbl[r].rst) do_reset();
      @(negedge clk);
      valid = tbl[r].v;
      d0 = tbl[r].d0; d1 = tbl[r].d1; a0 = tbl[r].a0; a1 = tbl[r].a1;
      #1;
      chk("ready", r, 32'(ready), 32'(tbl[r].rdy));
      chk("cs",    r, 32'(cs),    32'(tbl[r].cs));
      chk("oe",    r, 32'(oe),    32'(tbl[r].cs));
      chk("grant", r, 32'(grant), 32'(tbl[r].gnt));
      chk("gpio",  r, 32'(gpio),  32'(tbl[r].gpio));
      chk("addr",  r, 32'(gaddr), 32'(tbl[r].addr));
      chk("busy",  r, 32'(busy),  32'(tbl[r].busy));
    end

    // Reset in the second DRIVE cycle aborts; req0 wins again afterwards.
    do_reset();
    @(negedge clk);
    valid = 2'b11; d0 = 8'h01; d1 = 8'h02; a0 = 4'd1; a1 = 4'd2;
    #1 chk("mid_ready0", 0, 32'(ready), 32'h1);
    @(negedge clk);
    #1 chk("mid_drive1", 0, {cs, grant, gpio}, {1'b1, 2'b01, 8'h01});
    @(negedge clk);
    #1 chk("mid_drive2", 0, {cs, grant, busy}, {1'b1, 2'b01, 1'b1});
    rstn = 1'b0;
    #1;
    chk("mid_rst_outs", 0, {cs, oe, busy, grant, gpio, gaddr}, 32'h0);
    chk("mid_rst_ready", 0, 32'(ready), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("mid_rel_ready", 0, 32'(ready), 32'h1);
    @(negedge clk);
    #1 chk("mid_rel_drive", 0, {cs, grant, gpio, gaddr}, {1'b1, 2'b01, 8'h01, 4'd1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
